// File: rtl/fod_dcw_pkg.sv
// Shared types and constants for the FOD DCW x4 generator.
// Lane widths, reset codes and the run/idle state encoding.
package fod_dcw_pkg;
    localparam int NLANE = 4;
    localparam int MMD_W = 6;
    localparam int DTC_W = 10;
    localparam int PHE_W = 3;

    typedef logic [MMD_W-1:0] mmd_t;
    typedef logic [DTC_W-1:0] dtc_t;
    typedef logic [PHE_W-1:0] phe_t;

    localparam mmd_t MMD_RST  = 6'd4;
    localparam mmd_t MMD_MAX  = 6'd63;
    localparam dtc_t KDTC_MAX = 10'd1023;

    typedef enum logic {
        IDLE,
        RUN
    } dcw_state_t;
endpackage

// File: rtl/fod_dcw_lane.sv
// One lane of the x4 ripple: fractional add, MMD carry,
// DTC scaling by the current gain and the RT edge select.
module fod_dcw_lane
    import fod_dcw_pkg::*;
#(
    parameter int FRAC_W = 16,
    parameter int RT_THR = 512
) (
    input  logic [FRAC_W-1:0] a_in,
    input  logic [FRAC_W-1:0] fcw_f,
    input  mmd_t              fcw_i,
    input  dtc_t              kdtc,
    output logic [FRAC_W-1:0] a_out,
    output mmd_t              mmd,
    output logic              ovf,
    output dtc_t              dtc,
    output logic              rt
);
    localparam dtc_t RT_C = dtc_t'(RT_THR);

    logic [FRAC_W:0]      sum;
    logic [MMD_W:0]       mmd_sum;
    logic [2*DTC_W-1:0]   prod;
    logic                 unused_lo;

    // Phase step, saturating divider word and scaled DTC code.
    always_comb begin
        sum     = {1'b0, a_in} + {1'b0, fcw_f};
        a_out   = sum[FRAC_W-1:0];
        mmd_sum = {1'b0, fcw_i} + {{MMD_W{1'b0}}, sum[FRAC_W]};
        ovf     = mmd_sum[MMD_W];
        mmd     = ovf ? MMD_MAX : mmd_sum[MMD_W-1:0];
        prod    = {{DTC_W{1'b0}}, a_out[FRAC_W-1 -: DTC_W]}
                * {{DTC_W{1'b0}}, kdtc};
        dtc     = prod[2*DTC_W-1:DTC_W];
        rt      = (dtc >= RT_C);
    end

    assign unused_lo = ^prod[DTC_W-1:0];
endmodule

// File: rtl/fod_dcw_gen_x4.sv
// FOD DCW x4 producer: accumulator, output registers, FSM, gain.
// Optional sign-sign LMS gain tracking under FOD_DCW_LMS_EN.
module fod_dcw_gen_x4
    import fod_dcw_pkg::*;
#(
    parameter int FRAC_W  = 16,
    parameter int PHE_LAT = 3,
    parameter int PHE_REF = 4,
    parameter int RT_THR  = 512,
    parameter int MU_SH   = 0
) (
    input  logic              DIG_CLK,
    input  logic              NARST,
    input  logic              EN,
    input  logic [5:0]        FCW_I,
    input  logic [FRAC_W-1:0] FCW_F,
    input  logic [9:0]        KDTC_INIT,
    input  logic [11:0]       PHE_X4,
    output logic [23:0]       MMD_DCW_X4,
    output logic [39:0]       DTC_DCW_X4,
    output logic [3:0]        RT_DCW_X4,
    output logic [9:0]        KDTC,
    output logic              DCW_OVF
);
    dcw_state_t             state_q, state_d;
    logic [FRAC_W-1:0]      acc_q, acc_d;
    mmd_t [NLANE-1:0]       mmd_q, mmd_d;
    dtc_t [NLANE-1:0]       dtc_q, dtc_d;
    logic [NLANE-1:0]       rt_q, rt_d;
    logic                   ovf_q, ovf_d;
    dtc_t                   kdtc_q, kdtc_d;

    logic [FRAC_W-1:0]      a_ch [NLANE+1];
    mmd_t [NLANE-1:0]       l_mmd;
    dtc_t [NLANE-1:0]       l_dtc;
    logic [NLANE-1:0]       l_rt;
    logic [NLANE-1:0]       l_ovf;
    logic [NLANE-1:0]       cur_msb;

    assign a_ch[0] = acc_q;

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        fod_dcw_lane #(
            .FRAC_W (FRAC_W),
            .RT_THR (RT_THR)
        ) u_lane (
            .a_in  (a_ch[k]),
            .fcw_f (FCW_F),
            .fcw_i (FCW_I),
            .kdtc  (kdtc_q),
            .a_out (a_ch[k+1]),
            .mmd   (l_mmd[k]),
            .ovf   (l_ovf[k]),
            .dtc   (l_dtc[k]),
            .rt    (l_rt[k])
        );
        assign cur_msb[k] = a_ch[k+1][FRAC_W-1];
    end

    // Next state and next output words; idle forces reset codes.
    always_comb begin
        state_d = state_q;
        acc_d   = '0;
        mmd_d   = {NLANE{MMD_RST}};
        dtc_d   = '0;
        rt_d    = '0;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE:    if (EN)  state_d = RUN;
            RUN:     if (!EN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (EN) begin
            acc_d = a_ch[NLANE];
            mmd_d = l_mmd;
            dtc_d = l_dtc;
            rt_d  = l_rt;
            ovf_d = ovf_q | (|l_ovf);
        end
    end

    // Main register bank with synchronous active-low reset.
    always_ff @(posedge DIG_CLK) begin
        if (!NARST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mmd_q   <= {NLANE{MMD_RST}};
            dtc_q   <= '0;
            rt_q    <= '0;
            ovf_q   <= 1'b0;
            kdtc_q  <= KDTC_INIT;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mmd_q   <= mmd_d;
            dtc_q   <= dtc_d;
            rt_q    <= rt_d;
            ovf_q   <= ovf_d;
            kdtc_q  <= kdtc_d;
        end
    end

`ifdef FOD_DCW_LMS_EN
    localparam logic [7:0] LAT_C = 8'(PHE_LAT);

    logic [NLANE-1:0] msb_q [PHE_LAT];
    logic [NLANE-1:0] msb_d [PHE_LAT];
    logic [7:0]       wcnt_q, wcnt_d;
    int               err   [NLANE];
    int               sgn   [NLANE];
    int               delta;
    int               kdtc_n;

    // Residue-sign delay line aligned with the returning PHE lanes.
    always_comb begin
        msb_d[0] = EN ? cur_msb : '0;
        for (int i = 1; i < PHE_LAT; i++) begin
            msb_d[i] = msb_q[i-1];
        end
        wcnt_d = wcnt_q;
        if (!EN) begin
            wcnt_d = '0;
        end else if (wcnt_q < LAT_C) begin
            wcnt_d = wcnt_q + 8'd1;
        end
    end

    // Sign-sign LMS step on the gain, saturated to 0..1023.
    always_comb begin
        delta = 0;
        for (int k = 0; k < NLANE; k++) begin
            err[k] = int'(PHE_X4[PHE_W*k +: PHE_W]) - PHE_REF;
            sgn[k] = (err[k] > 0) ? 1 : ((err[k] < 0) ? -1 : 0);
            if (msb_q[PHE_LAT-1][k]) begin
                delta = delta - sgn[k];
            end else begin
                delta = delta + sgn[k];
            end
        end
        kdtc_n = int'(kdtc_q) - (delta <<< MU_SH);
        kdtc_d = kdtc_q;
        if (state_q == IDLE) begin
            kdtc_d = KDTC_INIT;
        end else if (EN && (wcnt_q >= LAT_C)) begin
            if (kdtc_n < 0) begin
                kdtc_d = '0;
            end else if (kdtc_n > 1023) begin
                kdtc_d = KDTC_MAX;
            end else begin
                kdtc_d = dtc_t'(kdtc_n);
            end
        end
    end

    // LMS state registers.
    always_ff @(posedge DIG_CLK) begin
        if (!NARST) begin
            wcnt_q <= '0;
            for (int i = 0; i < PHE_LAT; i++) begin
                msb_q[i] <= '0;
            end
        end else begin
            wcnt_q <= wcnt_d;
            for (int i = 0; i < PHE_LAT; i++) begin
                msb_q[i] <= msb_d[i];
            end
        end
    end
`else
    logic unused_cfg;

    // Fixed gain: follow KDTC_INIT through one register.
    always_comb begin
        kdtc_d = KDTC_INIT;
    end

    assign unused_cfg = ^{PHE_X4, cur_msb, PHE_LAT[0],
                          PHE_REF[0], MU_SH[0]};
`endif

    assign MMD_DCW_X4 = mmd_q;
    assign DTC_DCW_X4 = dtc_q;
    assign RT_DCW_X4  = rt_q;
    assign KDTC       = kdtc_q;
    assign DCW_OVF    = ovf_q;
endmodule

// File: tb/tb_fod_dcw_gen_x4.sv
// Scoreboard bench for fod_dcw_gen_x4 (covers FOD_DCW_LMS_EN too).
// Reference model computes lane phases from acc + (k+1)*FCW_F.
module tb_fod_dcw_gen_x4;
    localparam int LAT = 3;
    localparam int REF = 4;
    localparam int MU  = 0;

    logic        clk = 1'b0;
    logic        NARST, EN;
    logic [5:0]  FCW_I;
    logic [15:0] FCW_F;
    logic [9:0]  KDTC_INIT;
    logic [11:0] PHE_X4;
    logic [23:0] MMD_DCW_X4;
    logic [39:0] DTC_DCW_X4;
    logic [3:0]  RT_DCW_X4;
    logic [9:0]  KDTC;
    logic        DCW_OVF;

    typedef struct {
        logic [23:0] mmd;
        logic [39:0] dtc;
        logic [3:0]  rt;
        logic [9:0]  kdtc;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int          m_acc, m_kdtc;
    bit          m_ovf, m_run;
    logic [3:0]  m_hist[$];

    always #5 clk = ~clk;

    fod_dcw_gen_x4 dut (
        .DIG_CLK    (clk),
        .NARST      (NARST),
        .EN         (EN),
        .FCW_I      (FCW_I),
        .FCW_F      (FCW_F),
        .KDTC_INIT  (KDTC_INIT),
        .PHE_X4     (PHE_X4),
        .MMD_DCW_X4 (MMD_DCW_X4),
        .DTC_DCW_X4 (DTC_DCW_X4),
        .RT_DCW_X4  (RT_DCW_X4),
        .KDTC       (KDTC),
        .DCW_OVF    (DCW_OVF)
    );

    task automatic chk(input string nm, input logic [39:0] act,
                       input logic [39:0] exq);
        n_cmp++;
        if (act !== exq) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h",
                     nm, $time, act, exq);
        end
    endtask

    // Monitor: one registered output word set per clock.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mmd",  {16'd0, MMD_DCW_X4}, {16'd0, e.mmd});
            chk("dtc",  DTC_DCW_X4,          e.dtc);
            chk("rt",   {36'd0, RT_DCW_X4},  {36'd0, e.rt});
            chk("kdtc", {30'd0, KDTC},       {30'd0, e.kdtc});
            chk("ovf",  {39'd0, DCW_OVF},    {39'd0, e.ovf});
        end
    end

    task automatic model_edge(input bit nrst, input bit en,
                              input int fi, input int ff, input int ki,
                              input logic [11:0] phe, output exp_t e);
        int p, pp, c, m, d, nk, delta, er, sg;
        logic [3:0] msb, old;
        e.mmd = {4{6'd4}};
        e.dtc = '0;
        e.rt  = '0;
        msb   = '0;
        if (!nrst) begin
            m_acc = 0; m_ovf = 0; m_kdtc = ki; m_run = 0;
            m_hist.delete();
        end else begin
            if (en) begin
                for (int k = 0; k < 4; k++) begin
                    p  = m_acc + (k + 1) * ff;
                    pp = m_acc + k * ff;
                    c  = (p / 65536) - (pp / 65536);
                    p  = p % 65536;
                    m  = fi + c;
                    if (m > 63) begin
                        m = 63;
                        m_ovf = 1;
                    end
                    d = ((p / 64) * m_kdtc) / 1024;
                    e.mmd[6*k +: 6]  = 6'(m);
                    e.dtc[10*k +: 10] = 10'(d);
                    e.rt[k] = (d >= 512);
                    msb[k]  = (p >= 32768);
                end
                m_acc = (m_acc + 4 * ff) % 65536;
            end else begin
                m_acc = 0;
            end
`ifdef FOD_DCW_LMS_EN
            nk = m_kdtc;
            if (!m_run) begin
                nk = ki;
            end else if (en && m_hist.size() >= LAT) begin
                old = m_hist[m_hist.size() - LAT];
                delta = 0;
                for (int k = 0; k < 4; k++) begin
                    er = int'(phe[3*k +: 3]) - REF;
                    sg = (er > 0) ? 1 : ((er < 0) ? -1 : 0);
                    delta += old[k] ? -sg : sg;
                end
                nk = m_kdtc - delta * (1 << MU);
                if (nk < 0) nk = 0;
                if (nk > 1023) nk = 1023;
            end
            if (en) begin
                m_hist.push_back(msb);
                while (m_hist.size() > LAT) void'(m_hist.pop_front());
            end else begin
                m_hist.delete();
            end
`else
            nk = ki;
            if (phe == 12'hfff && msb == 4'hf) nk = ki;
`endif
            m_run  = en;
            m_kdtc = nk;
        end
        e.kdtc = 10'(m_kdtc);
        e.ovf  = m_ovf;
    endtask

    task automatic step(input bit nrst, input bit en, input int fi,
                        input int ff, input int ki,
                        input logic [11:0] phe);
        exp_t e;
        NARST = nrst; EN = en;
        FCW_I = 6'(fi); FCW_F = 16'(ff);
        KDTC_INIT = 10'(ki); PHE_X4 = phe;
        model_edge(nrst, en, fi, ff, ki, phe, e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        int fi, ff, ki;
        bit en, nr;
        logic [11:0] phe;
        step(0, 0, 8, 16'h4000, 1023, 12'o4444);
        step(0, 0, 8, 16'h4000, 1023, 12'o4444);
        for (int i = 0; i < 8; i++) step(1, 1, 8, 16'h4000, 1023, 12'o4444);
        step(0, 1, 8, 16'h4000, 1023, 12'o4444);
        for (int i = 0; i < 5; i++) step(1, 1, 8, 16'h4000, 1023, 12'o4444);
        for (int i = 0; i < 2; i++) step(1, 0, 8, 16'h4000, 1023, 12'o4444);
        for (int i = 0; i < 5; i++) step(1, 1, 8, 16'h4000, 1023, 12'o4444);
        for (int i = 0; i < 4; i++) step(1, 1, 63, 16'h8000, 1023, 12'o4444);
        for (int i = 0; i < 3; i++) step(1, 1, 8, 16'h4000, 1023, 12'o4444);
        step(0, 0, 8, 0, 512, 12'o6666);
        for (int i = 0; i < 140; i++) step(1, 1, 8, 0, 512, 12'o6666);
        step(0, 0, 8, 0, 1020, 12'o2222);
        for (int i = 0; i < 8; i++) step(1, 1, 8, 0, 1020, 12'o2222);
        step(0, 0, 8, 0, 1020, 12'o4444);
        for (int i = 0; i < 8; i++) step(1, 1, 8, 0, 1020, 12'o4444);
        ki = 700;
        for (int i = 0; i < 400; i++) begin
            nr  = ($urandom_range(0, 49) != 0);
            en  = ($urandom_range(0, 7) != 0);
            fi  = $urandom_range(0, 63);
            ff  = $urandom_range(0, 65535);
            if ($urandom_range(0, 19) == 0) ki = $urandom_range(0, 1023);
            phe = 12'($urandom);
            step(nr, en, fi, ff, ki, phe);
        end
        #20;
        chk("drain", 40'(exp_q.size()), 40'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
